// File: rtl/fir_sample_sink.sv
// ---------------------------------------------------------------------------
// fir_sample_sink
//
// Receiving end of the FIR sample stream. Each filtered sample arrives on a
// one-cycle strobe, is buffered in a small circular FIFO and is handed to the
// downstream consumer (logger / serializer) over a valid/ready handshake.
// Alongside the data path the block watches the spacing between strobes and
// raises sticky flags when a sample had to be dropped or when a strobe came
// early or late.
//
// Parameters
//   WIDTH   sample width, signed two's complement (stored bit-exact)
//   DEPTH   FIFO depth in entries, power of two, at least 2
//   PERIOD  expected number of clk cycles between consecutive strobes
//
// Ports
//   clk_i          system clock, every register updates on the rising edge
//   rst_i          synchronous active-high reset
//   in_sample_i    filtered sample, meaningful while in_strobe_i is high
//   in_strobe_i    one-cycle capture pulse for in_sample_i
//   out_data_o     sample at the head of the FIFO (registered)
//   out_valid_o    out_data_o holds a sample (registered, level != 0)
//   out_ready_i    downstream accepts out_data_o this cycle
//   level_o        number of stored samples, 0..DEPTH
//   overflow_o     sticky: a strobed sample was dropped because FIFO was full
//   period_err_o   sticky: strobe spacing differed from PERIOD
//   sample_cnt_o   count of accepted samples, wraps 65535 -> 0
// ---------------------------------------------------------------------------
module fir_sample_sink #(
    parameter int WIDTH  = 20,
    parameter int DEPTH  = 8,
    parameter int PERIOD = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         in_sample_i,
    input  logic                     in_strobe_i,
    output logic [WIDTH-1:0]         out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic                     period_err_o,
    output logic [15:0]              sample_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Level value that means "every slot occupied".
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    // Spacing value the counter must show when a well-timed strobe arrives:
    // the counter restarts at 1 on a strobe and counts up once per cycle, so
    // after PERIOD cycles it reads exactly PERIOD.
    localparam logic [15:0] PERIOD_CNT = 16'(PERIOD);
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [LVL_W-1:0] level_q,      level_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic             out_valid_q,  out_valid_d;
    logic             overflow_q,   overflow_d;
    logic             period_err_q, period_err_d;
    logic [15:0]      sample_cnt_q, sample_cnt_d;
    logic [15:0]      spacing_q,    spacing_d;
    logic             armed_q,      armed_d;

    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // -----------------------------------------------------------------------
    // Handshake decode
    // A pop happens whenever the registered valid meets ready. A push is
    // allowed when there is room, or when the FIFO is full but a pop on the
    // same edge frees a slot. A strobe that finds the FIFO full with no pop
    // is dropped and recorded in the overflow flag.
    // -----------------------------------------------------------------------
    always_comb begin
        full = (level_q == FULL_LEVEL);
        pop  = out_valid_q & out_ready_i;
        push = in_strobe_i & (~full | pop);
        drop = in_strobe_i & full & ~pop;
    end

    // -----------------------------------------------------------------------
    // FIFO bookkeeping: pointers advance by one and wrap naturally because
    // DEPTH is a power of two; the level only moves when exactly one of
    // push/pop happens.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered head-of-FIFO output.
    // The next head lives at rd_ptr_d. If that slot is the one being written
    // on this very edge (FIFO empty, or holding one entry that is popped
    // while a new one arrives) the memory does not hold it yet, so the
    // incoming sample is forwarded into the output register instead. This is
    // what gives the one-cycle strobe-to-valid latency without a same-cycle
    // combinational bypass. When the FIFO drains to empty the last value is
    // simply held; it is not meaningful while valid is low.
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid_d = (level_d != '0);
        out_data_d  = out_data_q;

        if (level_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                out_data_d = in_sample_i;
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Status: sticky overflow, accepted-sample counter and strobe spacing.
    // The spacing counter saturates so a long gap cannot wrap around and
    // alias to a correct spacing. The first strobe after reset only arms the
    // checker because there is no earlier strobe to measure against.
    // -----------------------------------------------------------------------
    always_comb begin
        overflow_d   = overflow_q | drop;
        sample_cnt_d = sample_cnt_q;
        spacing_d    = spacing_q;
        armed_d      = armed_q;
        period_err_d = period_err_q;

        if (push) begin
            sample_cnt_d = sample_cnt_q + 16'd1;
        end

        if (in_strobe_i) begin
            spacing_d = 16'd1;
            armed_d   = 1'b1;
            if (armed_q && (spacing_q != PERIOD_CNT)) begin
                period_err_d = 1'b1;
            end
        end else if (spacing_q != CNT_MAX) begin
            spacing_d = spacing_q + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Sample storage. The memory is not reset: after reset both pointers and
    // the level are zero, so whatever the slots still contain is unreachable
    // until it has been overwritten by a fresh push.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_sample_i;
        end
    end

    // -----------------------------------------------------------------------
    // Control and status registers with synchronous reset. A reset in the
    // middle of a stream throws away every stored sample and clears both
    // sticky flags and the spacing checker.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            period_err_q <= 1'b0;
            sample_cnt_q <= '0;
            spacing_q    <= '0;
            armed_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            period_err_q <= period_err_d;
            sample_cnt_q <= sample_cnt_d;
            spacing_q    <= spacing_d;
            armed_q      <= armed_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs come straight from registers.
    // -----------------------------------------------------------------------
    always_comb begin
        out_data_o   = out_data_q;
        out_valid_o  = out_valid_q;
        level_o      = level_q;
        overflow_o   = overflow_q;
        period_err_o = period_err_q;
        sample_cnt_o = sample_cnt_q;
    end

endmodule
